seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 122 ++++++++++++
 tb/tb_seven_seg_scanner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed 7-segment scanner: frame-shadowed BCD, anti-ghost blanking, leading-zero suppression.
// Latency: outputs registered, one cycle after the state they reflect; no backpressure (free-running scan).
module seven_seg_scanner #(
    parameter int         CLK_FREQ_HZ  = 50_000_000,
    parameter int         SCAN_HZ      = 1000,
    parameter int         BLANK_CYCLES = 64,
    parameter logic [5:0] DP_MASK      = 6'b010100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bcd_data_in,
    input  logic        blank_en,
    output logic [5:0]  an_out,
    output logic [6:0]  seg_out,
    output logic        dp_out
);

    localparam int              TICK_DIV  = CLK_FREQ_HZ / SCAN_HZ;
    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [7:0]      DP_EXT    = {2'b00, DP_MASK};

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [23:0]   shadow_q, shadow_d;
    logic [5:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    digit [8];
    logic [7:0]    zero_from;
    logic          run_zero;
    logic [3:0]    cur_digit;
    logic          lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        pre_d    = pre_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        if (pre_q == '0 && idx_q == 3'd0) begin
            shadow_d = bcd_data_in;
        end
        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end else begin
            pre_d = pre_q + PW'(1);
        end
    end

    // zero_from[k] is set when digit k and every digit above it are zero;
    // slots 6 and 7 are padding so the index never selects outside the array.
    always_comb begin
        for (int k = 0; k < 6; k++) begin
            digit[k] = shadow_q[4*k +: 4];
        end
        digit[6] = 4'd0;
        digit[7] = 4'd0;
        run_zero = 1'b1;
        zero_from = '0;
        for (int k = 7; k >= 0; k--) begin
            run_zero     = run_zero & (digit[k] == 4'd0);
            zero_from[k] = run_zero;
        end
    end

    assign cur_digit = digit[idx_q];
    assign lz_blank  = blank_en && (idx_q >= 3'd2) && zero_from[idx_q];

    always_comb begin
        an_d  = 6'h3F;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (pre_q >= BLANK_END) begin
            an_d  = ~(6'b000001 << idx_q);
            seg_d = lz_blank ? 7'h7F : decode(cur_digit);
            dp_d  = ~DP_EXT[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q    <= '0;
            idx_q    <= 3'd0;
            shadow_q <= '0;
            an_q     <= 6'h3F;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign an_out  = an_q;
    assign seg_out = seg_q;
    assign dp_out  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: cycle-count reference model plus directed probes and random input traffic.
module tb_seven_seg_scanner;

    localparam int         TICK  = 10;
    localparam int         BLK   = 2;
    localparam int         FRAME = 6 * TICK;
    localparam logic [5:0] DPM   = 6'b010100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] bcd = 24'h0;
    logic        blank_en = 1'b0;
    logic [5:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cnt = 0;
    logic [23:0] m_shadow = 24'h0;

    seven_seg_scanner #(
        .CLK_FREQ_HZ (1000),
        .SCAN_HZ     (100),
        .BLANK_CYCLES(BLK),
        .DP_MASK     (DPM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_data_in(bcd),
        .blank_en   (blank_en),
        .an_out     (an_out),
        .seg_out    (seg_out),
        .dp_out     (dp_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Expected {an, seg, dp} after the edge whose pre-edge cycle count within the run is c.
    function automatic logic [13:0] model_out(input int c, input logic [23:0] sh, input logic be);
        int          pres;
        int          idx;
        int          d;
        logic [23:0] upper;
        logic [5:0]  an;
        logic [6:0]  seg;
        pres = c % TICK;
        idx  = (c / TICK) % 6;
        if (pres < BLK) return {6'h3F, 7'h7F, 1'b1};
        upper = sh >> (4 * idx);
        d     = int'(upper & 24'hF);
        an    = 6'h3F;
        an[idx] = 1'b0;
        if (be && idx >= 2 && upper == 24'h0) seg = 7'h7F;
        else seg = seg_of(d);
        return {an, seg, ~DPM[idx]};
    endfunction

    task automatic step();
        logic [13:0] exp;
        @(posedge clk);
        exp = model_out(cnt, m_shadow, blank_en);
        if (cnt % FRAME == 0) m_shadow = bcd;
        cnt++;
        #1;
        chk("model", {18'h0, an_out, seg_out, dp_out}, {18'h0, exp});
    endtask

    task automatic probe(input string tag, input int pos, input logic [5:0] an,
                         input logic [6:0] seg, input logic dp);
        bit hit;
        hit = 0;
        for (int i = 0; i < FRAME + 10 && !hit; i++) begin
            step();
            if ((cnt - 1) % FRAME == pos) hit = 1;
        end
        if (!hit) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else chk(tag, {18'h0, an_out, seg_out, dp_out}, {18'h0, an, seg, dp});
    endtask

    function automatic logic [23:0] rand_bcd();
        logic [23:0] v;
        for (int k = 0; k < 6; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        return v;
    endfunction

    initial begin
        bcd = 24'hABCDEF;
        #12;
        chk("reset_an", {26'h0, an_out}, {26'h0, 6'h3F});
        chk("reset_seg", {25'h0, seg_out}, {25'h0, 7'h7F});
        chk("reset_dp", {31'h0, dp_out}, 32'h1);

        // scan order
        bcd = 24'h012345;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        m_shadow = 24'h0;
        probe("scan_d0", 5, 6'b111110, 7'b0010010, 1'b1);
        probe("scan_d1_first", 12, 6'b111101, 7'b0011001, 1'b1);
        probe("scan_d2", 25, 6'b111011, 7'b0110000, 1'b0);
        probe("scan_d4", 45, 6'b101111, 7'b1111001, 1'b0);
        probe("scan_d5", 55, 6'b011111, 7'b1000000, 1'b1);
        probe("scan_blank", 1, 6'h3F, 7'h7F, 1'b1);

        // leading-zero blanking
        bcd = 24'h000507;
        blank_en = 1'b1;
        probe("lz_cap", 0, 6'h3F, 7'h7F, 1'b1);
        probe("lz_d0", 5, 6'b111110, 7'b1111000, 1'b1);
        probe("lz_d1", 15, 6'b111101, 7'b1000000, 1'b1);
        probe("lz_d2", 25, 6'b111011, 7'b0010010, 1'b0);
        probe("lz_d3", 35, 6'b110111, 7'h7F, 1'b1);
        probe("lz_d4", 45, 6'b101111, 7'h7F, 1'b0);
        probe("lz_d5", 55, 6'b011111, 7'h7F, 1'b1);
        blank_en = 1'b0;
        probe("nolz_d3", 35, 6'b110111, 7'b1000000, 1'b1);
        probe("nolz_d5", 55, 6'b011111, 7'b1000000, 1'b1);

        // tear-free update
        bcd = 24'h000000;
        probe("tear_cap", 0, 6'h3F, 7'h7F, 1'b1);
        probe("tear_d2", 25, 6'b111011, 7'b1000000, 1'b0);
        bcd = 24'h888888;
        probe("tear_d3", 35, 6'b110111, 7'b1000000, 1'b1);
        probe("tear_d4", 45, 6'b101111, 7'b1000000, 1'b0);
        probe("tear_d5", 55, 6'b011111, 7'b1000000, 1'b1);
        probe("tear_next_d0", 5, 6'b111110, 7'b0000000, 1'b1);
        probe("tear_next_d5", 55, 6'b011111, 7'b0000000, 1'b1);

        // invalid digit
        bcd = 24'h00A000;
        blank_en = 1'b1;
        probe("inv_cap", 0, 6'h3F, 7'h7F, 1'b1);
        probe("inv_d2", 25, 6'b111011, 7'b1000000, 1'b0);
        probe("inv_d3", 35, 6'b110111, 7'b0111111, 1'b1);
        probe("inv_d4", 45, 6'b101111, 7'h7F, 1'b0);
        probe("inv_d5", 55, 6'b011111, 7'h7F, 1'b1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) bcd = rand_bcd();
            if ($urandom_range(0, 99) == 0) blank_en = ~blank_en;
            step();
        end

        // asynchronous reset mid-slot with digit 3 lit
        bcd = 24'h123456;
        blank_en = 1'b0;
        probe("pre_rst_cap", 0, 6'h3F, 7'h7F, 1'b1);
        probe("pre_rst_d3", 35, 6'b110111, 7'b0110000, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_an", {26'h0, an_out}, {26'h0, 6'h3F});
        chk("arst_seg", {25'h0, seg_out}, {25'h0, 7'h7F});
        chk("arst_dp", {31'h0, dp_out}, 32'h1);
        @(posedge clk);
        #1;
        chk("hold_rst", {18'h0, an_out, seg_out, dp_out}, {18'h0, 6'h3F, 7'h7F, 1'b1});
        bcd = 24'h987654;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        m_shadow = 24'h0;
        step();
        chk("post_rst_edge0", {18'h0, an_out, seg_out, dp_out}, {18'h0, 6'h3F, 7'h7F, 1'b1});
        probe("post_rst_d0", 5, 6'b111110, 7'b0011001, 1'b1);
        probe("post_rst_d5", 55, 6'b011111, 7'b0010000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
